// File: rtl/sram_pkg.sv
// Shared types and sizing for the 32-bit-over-16-bit SRAM controller.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WORD_IDX_W  = SRAM_ADDR_W - 1;
  localparam int unsigned PHASE_CNT_W = 4;

  localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sram_phase_counter.sv
// Counts the cycles of one SRAM half-access and flags its last cycle.
module sram_phase_counter
  import sram_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  logic [PHASE_CNT_W-1:0] cnt;

  // Terminal count marks the final cycle of the current phase.
  assign tc_c = (cnt == PHASE_CNT_W'(PHASE_CYCLES - 1));

  // Counter wraps at terminal count so LO hands a fresh count to HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc_c ? '0 : cnt + PHASE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline load/store into two 16-bit SRAM accesses.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter logic [31:0] DATA_BASE    = DATA_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t state, next_state;

  logic                   is_wr_q;
  logic [WORD_IDX_W-1:0]  idx_q;
  logic [SRAM_DATA_W-1:0] wdata_hi_q;

  logic [31:0]            offset_c;
  logic [WORD_IDX_W-1:0]  idx_c;
  logic                   tc_c;
  logic                   start_c;
  logic                   cnt_clear_c;

  logic [SRAM_ADDR_W-1:0] addr_d;
  logic [SRAM_DATA_W-1:0] dq_out_d;
  logic                   oe_d;
  logic                   we_n_d;
  logic                   cap_lo_c;
  logic                   cap_hi_c;

  // Word index wraps freely; addresses below DATA_BASE alias high SRAM words.
  assign offset_c    = address - DATA_BASE;
  assign idx_c       = WORD_IDX_W'(offset_c >> 2);
  assign start_c     = (state == IDLE) && (rd_en || wr_en);
  assign cnt_clear_c = (state != LO) && (state != HI);

  assign ready = (state == DONE) || ((state == IDLE) && !rd_en && !wr_en);

  sram_phase_counter #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear_c),
    .enable(!cnt_clear_c),
    .tc_c  (tc_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the SRAM pin values for the cycle being entered.
  always_comb begin
    next_state = state;
    addr_d     = sram_addr;
    dq_out_d   = sram_dq_out;
    oe_d       = sram_dq_oe;
    we_n_d     = sram_we_n;
    cap_lo_c   = 1'b0;
    cap_hi_c   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_en || wr_en) begin
          next_state = LO;
          addr_d     = {idx_c, 1'b0};
          oe_d       = wr_en;
          we_n_d     = !wr_en;
          if (wr_en) dq_out_d = write_data[15:0];
        end
      end
      LO: begin
        if (tc_c) begin
          next_state = HI;
          addr_d     = {idx_q, 1'b1};
          if (is_wr_q) dq_out_d = wdata_hi_q;
          else         cap_lo_c = 1'b1;
        end
      end
      HI: begin
        if (tc_c) begin
          next_state = DONE;
          oe_d       = 1'b0;
          we_n_d     = 1'b1;
          cap_hi_c   = !is_wr_q;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch: operation, word index and upper store half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_hi_q <= '0;
    end else if (start_c) begin
      is_wr_q    <= wr_en;
      idx_q      <= idx_c;
      wdata_hi_q <= write_data[31:16];
    end
  end

  // Registered SRAM pins and load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      read_data   <= '0;
    end else begin
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= oe_d;
      sram_we_n   <= we_n_d;
      if (cap_lo_c) read_data[15:0]  <= sram_dq_in;
      if (cap_hi_c) read_data[31:16] <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [16];

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq_in = (sram_addr < 18'd16) ? mem[sram_addr[3:0]] : 16'h0000;

  // SRAM model: preload, then accept writes while the strobe is low.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[2] = 16'h5678;
    mem[3] = 16'h1234;
    mem[6] = 16'hAAAA;
    mem[7] = 16'hBBBB;
    forever begin
      @(posedge clk);
      if (!sram_we_n && sram_addr < 18'd16) mem[sram_addr[3:0]] = sram_dq_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    wr_en = 1'b1; address = 32'd1056; write_data = 32'h99998888;
    tick();
    wr_en = 1'b0;
    tick();
    checks++;
    if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_active: got we_n=%b oe=%b expected we_n=0 oe=1", sram_we_n, sram_dq_oe);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n} !== {32'h0, 18'h0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_async: got rd=%h addr=%h dq=%h oe=%b we_n=%b expected rd=0 addr=0 dq=0 oe=0 we_n=1",
               read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_write();
    logic [17:0] ea;
    logic [15:0] ed;
    tick();
    wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL write_c0_ready: got %b expected 0", ready);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      wr_en = 1'b0;
      ea = (c <= 2) ? 18'd0 : 18'd1;
      ed = (c <= 2) ? 16'hBEEF : 16'hDEAD;
      checks++;
      if ({sram_addr, sram_dq_out, sram_we_n, sram_dq_oe, ready} !==
          {ea, ed, (c == 5), (c != 5), (c == 5)}) begin
        errors++;
        $display("FAIL write_c%0d: got addr=%h dq=%h we_n=%b oe=%b rdy=%b expected addr=%h dq=%h we_n=%b oe=%b rdy=%b",
                 c, sram_addr, sram_dq_out, sram_we_n, sram_dq_oe, ready, ea, ed, (c == 5), (c != 5), (c == 5));
      end
    end
    checks++;
    if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD || read_data !== 32'h0) begin
      errors++;
      $display("FAIL write_mem: got m0=%h m1=%h rd=%h expected m0=beef m1=dead rd=0", mem[0], mem[1], read_data);
    end
  endtask

  task automatic test_read();
    tick();
    rd_en = 1'b1; address = 32'd1028;
    for (int c = 1; c <= 5; c++) begin
      tick();
      rd_en = 1'b0;
      checks++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ready !== (c == 5)) begin
        errors++;
        $display("FAIL read_c%0d_ctl: got we_n=%b oe=%b rdy=%b expected we_n=1 oe=0 rdy=%b",
                 c, sram_we_n, sram_dq_oe, ready, (c == 5));
      end
      if (c == 2 || c == 4) begin
        checks++;
        if (sram_addr !== ((c == 2) ? 18'd2 : 18'd3)) begin
          errors++;
          $display("FAIL read_c%0d_addr: got %h expected %h", c, sram_addr, (c == 2) ? 18'd2 : 18'd3);
        end
      end
      if (c == 3) begin
        checks++;
        if (read_data !== 32'h00005678) begin
          errors++;
          $display("FAIL read_c3_low: got %h expected 00005678", read_data);
        end
      end
    end
    checks++;
    if (read_data !== 32'h12345678) begin
      errors++;
      $display("FAIL read_data: got %h expected 12345678", read_data);
    end
  endtask

  task automatic test_conflict();
    tick();
    rd_en = 1'b1; wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
    for (int c = 1; c <= 5; c++) begin
      tick();
      rd_en = 1'b0; wr_en = 1'b0;
      if (c == 1 || c == 3) begin
        checks++;
        if (sram_addr !== ((c == 1) ? 18'd4 : 18'd5) || sram_we_n !== 1'b0) begin
          errors++;
          $display("FAIL conflict_c%0d: got addr=%h we_n=%b expected addr=%h we_n=0",
                   c, sram_addr, sram_we_n, (c == 1) ? 18'd4 : 18'd5);
        end
      end
    end
    checks++;
    if (mem[4] !== 16'hF00D || mem[5] !== 16'hCAFE || read_data !== 32'h12345678) begin
      errors++;
      $display("FAIL conflict_result: got m4=%h m5=%h rd=%h expected m4=f00d m5=cafe rd=12345678",
               mem[4], mem[5], read_data);
    end
  endtask

  task automatic test_wrap();
    logic [17:0] ea;
    tick();
    wr_en = 1'b1; address = 32'd0; write_data = 32'h01020304;
    for (int c = 1; c <= 5; c++) begin
      tick();
      wr_en = 1'b0;
      if (c <= 4) begin
        ea = (c <= 2) ? 18'h3FE00 : 18'h3FE01;
        checks++;
        if (sram_addr !== ea) begin
          errors++;
          $display("FAIL wrap_c%0d: got %h expected %h", c, sram_addr, ea);
        end
      end
    end
  endtask

  task automatic test_abort();
    tick();
    rd_en = 1'b1; address = 32'd1036;
    for (int c = 1; c <= 3; c++) begin
      tick();
      rd_en = 1'b0;
    end
    checks++;
    if (read_data !== 32'h1234AAAA) begin
      errors++;
      $display("FAIL abort_pre: got %h expected 1234aaaa", read_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({read_data, sram_addr, sram_we_n, sram_dq_oe, ready} !== {32'h0, 18'h0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_reset: got rd=%h addr=%h we_n=%b oe=%b rdy=%b expected rd=0 addr=0 we_n=1 oe=0 rdy=1",
               read_data, sram_addr, sram_we_n, sram_dq_oe, ready);
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (sram_we_n !== 1'b1 || sram_addr !== 18'h0 || read_data !== 32'h0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_quiet_%0d: got we_n=%b addr=%h rd=%h rdy=%b expected we_n=1 addr=0 rd=0 rdy=1",
                 c, sram_we_n, sram_addr, read_data, ready);
      end
    end
    rd_en = 1'b1; address = 32'd1024;
    for (int c = 1; c <= 5; c++) begin
      tick();
      rd_en = 1'b0;
    end
    checks++;
    if (read_data !== 32'hDEADBEEF || ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_reread: got rd=%h rdy=%b expected rd=deadbeef rdy=1", read_data, ready);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    rd_en = 1'b1; address = 32'd1024;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 2) address = 32'd1028;
      if (c == 7) rd_en = 1'b0;
      if (c == 2) begin
        checks++;
        if (sram_addr !== 18'd0) begin
          errors++;
          $display("FAIL b2b_c2_addr: got %h expected 0", sram_addr);
        end
      end
      if (c == 5) begin
        checks++;
        if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL b2b_first: got rdy=%b rd=%h expected rdy=1 rd=deadbeef", ready, read_data);
        end
      end
      if (c == 6) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_c6_ready: got %b expected 0", ready);
        end
      end
      if (c == 7) begin
        checks++;
        if (sram_addr !== 18'd2 || ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_c7: got addr=%h rdy=%b expected addr=2 rdy=0", sram_addr, ready);
        end
      end
      if (c == 11) begin
        checks++;
        if (ready !== 1'b1 || read_data !== 32'h12345678) begin
          errors++;
          $display("FAIL b2b_second: got rdy=%b rd=%h expected rdy=1 rd=12345678", ready, read_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_conflict();
    test_wrap();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: PHASE_CYCLES, default 2, cycles each 16-bit SRAM half-access is held (legal 1..15).
REQ-002 Parameter: DATA_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 rd_en  in  1  pipeline MEM-stage load request.
REQ-006 wr_en  in  1  pipeline MEM-stage store request.
REQ-007 address  in  32  byte address from pipeline.
REQ-008 write_data  in  32  store data.
REQ-009 read_data  out  32  registered load data.
REQ-010 ready  out  1  high = no access pending or access completing; low = pipeline must freeze.
REQ-011 sram_addr  out  18  SRAM 16-bit-word address.
REQ-012 sram_dq_out  out  16  data driven toward SRAM.
REQ-013 sram_dq_in  in  16  data returned from SRAM.
REQ-014 sram_dq_oe  out  1  high = controller drives data bus.
REQ-015 sram_we_n  out  1  SRAM write strobe, active-low.

Function
REQ-016 States: IDLE, LO, HI, DONE; phase counter 0..PHASE_CYCLES-1.
REQ-017 IDLE with rd_en or wr_en high -> LO, counter cleared; address, write_data and op type latched on that edge.
REQ-018 Write wins when rd_en and wr_en are both high.
REQ-019 Word index = ((address - DATA_BASE) >> 2) in 32-bit arithmetic, truncated to 17 bits; no range check, underflow wraps (address 0 -> index 0x1FF00).
REQ-020 LO phase: sram_addr = {index,1'b0}; HI phase: sram_addr = {index,1'b1}; IDLE/DONE: sram_addr holds last value.
REQ-021 LO/HI each last exactly PHASE_CYCLES cycles; LO -> HI and HI -> DONE when counter = PHASE_CYCLES-1.
REQ-022 Write: sram_dq_oe=1, sram_we_n=0 throughout LO and HI; sram_dq_out = write_data[15:0] in LO, write_data[31:16] in HI; both strobes inactive in IDLE/DONE.
REQ-023 Read: sram_dq_oe=0, sram_we_n=1; read_data[15:0] captured from sram_dq_in on final LO cycle, read_data[31:16] on final HI cycle; read_data otherwise holds.
REQ-024 Write never modifies read_data.
REQ-025 DONE lasts one cycle, then -> IDLE unconditionally.
REQ-026 ready (combinational) = (state==DONE) or (state==IDLE and rd_en=0 and wr_en=0).
REQ-027 Latency: request first seen in IDLE at cycle 0 -> ready high in cycle 1+2*PHASE_CYCLES (cycle 5 at default).
REQ-028 Request inputs changing or dropping during LO/HI/DONE are ignored; latched operation completes.
REQ-029 Request still high in the IDLE cycle after DONE starts a new access (back-to-back allowed, one idle cycle minimum).

Reset
REQ-030 rst high: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, immediately and asynchronously.
REQ-031 rst asserted mid-access aborts it; no further SRAM strobes; partial read data discarded (read_data=0).
REQ-032 First access may begin on first rising edge after rst deasserts.

Structure
REQ-033 Package sram_pkg holds the state enumeration, DATA_BASE default, SRAM address/data widths.
REQ-034 One sub-module, sram_phase_counter (clear, enable, terminal-count output), instantiated once.

Verification
REQ-035 Reset: rst pulse mid-cycle -> all outputs at REQ-030 values before next edge; ready=1 with no request.
REQ-036 Write: wr_en, address=1024, write_data=0xDEADBEEF -> sram_addr 0 for 2 cycles with dq_out 0xBEEF, then 1 for 2 cycles with 0xDEAD, we_n=0 for 4 cycles, ready high at cycle 5.
REQ-037 Read: rd_en, address=1028, SRAM model returns 0x5678 at addr 2, 0x1234 at addr 3 -> read_data=0x12345678 and ready=1 at cycle 5.
REQ-038 Conflict: rd_en=wr_en=1, address=1032, data 0xCAFEF00D -> write performed to SRAM addr 4/5; read_data unchanged.
REQ-039 Wrap: wr_en, address=0 -> sram_addr 0x3FE00 then 0x3FE01.
REQ-040 Abort: rst at cycle 3 of a read -> state IDLE, read_data=0, no strobes; subsequent read of 1024 returns correct data.
